// File: rtl/alu_framer_pkg.sv
// Shared types and defaults for the ALU result framer.
package alu_framer_pkg;

   localparam int unsigned DEF_DATA_W    = 32;
   localparam int unsigned DEF_DEPTH     = 32;
   localparam int unsigned DEF_LEN_W     = 5;
   localparam int unsigned DEF_LQ_DEPTH  = 4;
   localparam int unsigned DEF_BP_MARGIN = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_FRAMING = 2'd2
   } fsm_state_e;

   // Occupancy counters carry one extra bit so a full FIFO never reads as empty.
   function automatic int unsigned occ_w(input int unsigned depth);
      return 32'($clog2(depth)) + 32'd1;
   endfunction

endpackage

// File: rtl/alu_pframer_if.sv
// Length-request, ALU-write and framed-output signals of the framer.
interface alu_pframer_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 5
);
   logic [LEN_W-1:0]  len_in;
   logic              len_val;
   logic              len_rdy;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              frame_bp;
   logic              frame_val;
   logic              frame_rdy;
   logic [DATA_W-1:0] frame_data;
   logic              frame_sof;
   logic              frame_eof;
   logic              ovf_err;
   logic              len_err;

   modport master (
      output len_in, len_val, alu_data, alu_ready, frame_rdy,
      input  len_rdy, frame_bp, frame_val, frame_data, frame_sof, frame_eof, ovf_err, len_err
   );

   modport slave (
      input  len_in, len_val, alu_data, alu_ready, frame_rdy,
      output len_rdy, frame_bp, frame_val, frame_data, frame_sof, frame_eof, ovf_err, len_err
   );
endinterface

// File: rtl/alu_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is taken only alongside a pop.
module alu_sync_fifo
   import alu_framer_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [WIDTH-1:0]      i_data,
   output logic [WIDTH-1:0]      o_data_c,
   output logic                  o_full_c,
   output logic                  o_empty_c,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = occ_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full_c  = (r_count == OCC_W'(DEPTH));
   assign o_empty_c = (r_count == '0);
   assign o_data_c  = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty_c;
   assign w_do_push = i_push && (!o_full_c || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + OCC_W'(w_do_push) - OCC_W'(w_do_pop);
      end
   end

endmodule

// File: rtl/alu_pframer.sv
// Buffers ALU words and emits one SOF/EOF-marked frame per queued length request.
module alu_pframer
   import alu_framer_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned LEN_W     = DEF_LEN_W,
   parameter int unsigned LQ_DEPTH  = DEF_LQ_DEPTH,
   parameter int unsigned BP_MARGIN = DEF_BP_MARGIN
) (
   input logic          clk,
   input logic          rst_n,
   alu_pframer_if.slave io_bus
);
   localparam int unsigned OCC_W    = occ_w(DEPTH);
   localparam int unsigned LQ_OCC_W = occ_w(LQ_DEPTH);
   localparam int unsigned CMP_W    = (OCC_W > LEN_W) ? OCC_W : LEN_W;
   localparam int unsigned BP_LEVEL = DEPTH - BP_MARGIN;

   fsm_state_e          r_state;
   fsm_state_e          w_state_nxt;
   logic [LEN_W-1:0]    r_remain;
   logic                r_first;
   logic                r_val;
   logic                r_sof;
   logic                r_eof;
   logic [DATA_W-1:0]   r_data;
   logic                r_ovf;
   logic                r_len_err;
   logic                r_bp;
   logic                r_len_rdy;

   logic [DATA_W-1:0]   w_dq_rdata;
   logic                w_dq_full;
   logic                w_dq_empty;
   logic [OCC_W-1:0]    w_dq_cnt;
   logic [LEN_W-1:0]    w_lq_data;
   logic                w_lq_full;
   logic                w_lq_empty;
   logic [LQ_OCC_W-1:0] w_lq_cnt;
   logic [LQ_OCC_W-1:0] w_lq_cnt_nxt;
   logic                w_lq_push;
   logic                w_lq_pop;
   logic                w_dq_pop;
   logic                w_drop;
   logic                w_out_ld;
   logic                w_len_zero;
   logic                w_len_big;
   logic                w_len_fits;
   logic                w_len_bad;
   logic                w_load_len;

   alu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_data_fifo (
      .clk(clk), .rst_n(rst_n),
      .i_push(io_bus.alu_ready), .i_pop(w_dq_pop), .i_data(io_bus.alu_data),
      .o_data_c(w_dq_rdata), .o_full_c(w_dq_full), .o_empty_c(w_dq_empty), .o_count(w_dq_cnt)
   );

   alu_sync_fifo #(.WIDTH(LEN_W), .DEPTH(LQ_DEPTH)) u_len_fifo (
      .clk(clk), .rst_n(rst_n),
      .i_push(w_lq_push), .i_pop(w_lq_pop), .i_data(io_bus.len_in),
      .o_data_c(w_lq_data), .o_full_c(w_lq_full), .o_empty_c(w_lq_empty), .o_count(w_lq_cnt)
   );

   assign w_lq_push    = io_bus.len_val && !w_lq_full;
   assign w_lq_cnt_nxt = w_lq_cnt + LQ_OCC_W'(w_lq_push) - LQ_OCC_W'(w_lq_pop);
   assign w_out_ld     = !r_val || io_bus.frame_rdy;
   assign w_dq_pop     = (r_state == ST_FRAMING) && w_out_ld && !w_dq_empty;
   assign w_drop       = io_bus.alu_ready && w_dq_full && !w_dq_pop;
   assign w_len_zero   = (w_lq_data == '0);
   assign w_len_big    = (CMP_W'(w_lq_data) > CMP_W'(DEPTH));
   assign w_len_fits   = (CMP_W'(w_dq_cnt) >= CMP_W'(w_lq_data));

   // Next-state: lengths are classified as they leave the queue in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_lq_pop    = 1'b0;
      w_len_bad   = 1'b0;
      w_load_len  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_lq_empty) begin
               w_lq_pop = 1'b1;
               if (w_len_big) begin
                  w_len_bad = 1'b1;
               end else if (!w_len_zero) begin
                  w_load_len  = 1'b1;
                  w_state_nxt = w_len_fits ? ST_FRAMING : ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            if (CMP_W'(w_dq_cnt) >= CMP_W'(r_remain)) w_state_nxt = ST_FRAMING;
         end
         ST_FRAMING: begin
            if (w_dq_pop && (r_remain == LEN_W'(1))) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Frame bookkeeping, output beat register and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_remain  <= '0;
         r_first   <= 1'b0;
         r_val     <= 1'b0;
         r_sof     <= 1'b0;
         r_eof     <= 1'b0;
         r_data    <= '0;
         r_ovf     <= 1'b0;
         r_len_err <= 1'b0;
         r_bp      <= 1'b0;
         r_len_rdy <= 1'b1;
      end else begin
         r_len_err <= w_len_bad;
         r_bp      <= (w_dq_cnt >= OCC_W'(BP_LEVEL));
         r_len_rdy <= (w_lq_cnt_nxt != LQ_OCC_W'(LQ_DEPTH));
         if (w_drop) r_ovf <= 1'b1;
         if (w_load_len) begin
            r_remain <= w_lq_data;
            r_first  <= 1'b1;
         end else if (w_dq_pop) begin
            r_remain <= r_remain - LEN_W'(1);
            r_first  <= 1'b0;
         end
         if (w_dq_pop) begin
            r_val  <= 1'b1;
            r_data <= w_dq_rdata;
            r_sof  <= r_first;
            r_eof  <= (r_remain == LEN_W'(1));
         end else if (r_val && io_bus.frame_rdy) begin
            r_val <= 1'b0;
            r_sof <= 1'b0;
            r_eof <= 1'b0;
         end
      end
   end

   assign io_bus.len_rdy    = r_len_rdy;
   assign io_bus.frame_bp   = r_bp;
   assign io_bus.frame_val  = r_val;
   assign io_bus.frame_data = r_data;
   assign io_bus.frame_sof  = r_sof;
   assign io_bus.frame_eof  = r_eof;
   assign io_bus.ovf_err    = r_ovf;
   assign io_bus.len_err    = r_len_err;

endmodule

// File: tb/tb_alu_pframer.sv
// Directed bench for alu_pframer: a DEPTH=32 instance plus a DEPTH=16 one for length errors.
module tb_alu_pframer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_pframer_if #(.DATA_W(32), .LEN_W(5)) bus32 ();
   alu_pframer_if #(.DATA_W(32), .LEN_W(5)) bus16 ();

   alu_pframer #(.DATA_W(32), .DEPTH(32), .LEN_W(5), .LQ_DEPTH(4), .BP_MARGIN(3)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .io_bus(bus32)
   );
   alu_pframer #(.DATA_W(32), .DEPTH(16), .LEN_W(5), .LQ_DEPTH(4), .BP_MARGIN(3)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .io_bus(bus16)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;
   logic [33:0] q_beat [$];
   int unsigned q_cyc [$];
   logic        hold_v    = 1'b0;
   logic [34:0] hold_beat = '0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Collect accepted beats and verify a stalled beat is held unchanged.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_v)
            chk_eq("stall_hold",
                   64'({bus32.frame_val, bus32.frame_sof, bus32.frame_eof, bus32.frame_data}),
                   64'(hold_beat));
         hold_v    = bus32.frame_val && !bus32.frame_rdy;
         hold_beat = {bus32.frame_val, bus32.frame_sof, bus32.frame_eof, bus32.frame_data};
         if (bus32.frame_val && bus32.frame_rdy) begin
            q_beat.push_back({bus32.frame_sof, bus32.frame_eof, bus32.frame_data});
            q_cyc.push_back(cyc);
         end
      end else begin
         hold_v = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      q_beat.delete();
      q_cyc.delete();
   endtask

   task automatic push32(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         bus32.alu_ready = 1'b1;
         bus32.alu_data  = base + 32'(i);
         tick();
      end
      bus32.alu_ready = 1'b0;
   endtask

   task automatic send_len32(input logic [4:0] l);
      int n = 0;
      while (!bus32.len_rdy && n < 50) begin
         tick();
         n++;
      end
      chk_eq("len_rdy_wait", 64'(bus32.len_rdy), 64'(1));
      bus32.len_val = 1'b1;
      bus32.len_in  = l;
      tick();
      bus32.len_val = 1'b0;
   endtask

   task automatic wait_beats(input int n, input string tag);
      int k = 0;
      while (q_beat.size() < n && k < 300) begin
         tick();
         k++;
      end
      chk_eq({tag, "_count"}, 64'(q_beat.size()), 64'(n));
   endtask

   task automatic expect_frame(input string tag, input logic [31:0] base, input int l, input int off);
      for (int i = 0; i < l; i++) begin
         logic [33:0] e;
         logic [33:0] got;
         e   = {1'(i == 0), 1'(i == l - 1), base + 32'(i)};
         got = (off + i < q_beat.size()) ? q_beat[off + i] : '1;
         chk_eq($sformatf("%s_b%0d", tag, i), 64'(got), 64'(e));
      end
   endtask

   initial begin
      logic        pat [4];
      logic [33:0] b16 [4];
      int          k;
      int          lerr;
      int          vals;
      int          nb;

      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      bus32.len_in = '0; bus32.len_val = 1'b0; bus32.alu_data = '0;
      bus32.alu_ready = 1'b0; bus32.frame_rdy = 1'b1;
      bus16.len_in = '0; bus16.len_val = 1'b0; bus16.alu_data = '0;
      bus16.alu_ready = 1'b0; bus16.frame_rdy = 1'b1;

      do_reset();
      chk_eq("rst_len_rdy",   64'(bus32.len_rdy),    64'(1));
      chk_eq("rst_frame_bp",  64'(bus32.frame_bp),   64'(0));
      chk_eq("rst_frame_val", 64'(bus32.frame_val),  64'(0));
      chk_eq("rst_sof",       64'(bus32.frame_sof),  64'(0));
      chk_eq("rst_eof",       64'(bus32.frame_eof),  64'(0));
      chk_eq("rst_data",      64'(bus32.frame_data), 64'(0));
      chk_eq("rst_ovf",       64'(bus32.ovf_err),    64'(0));
      chk_eq("rst_len_err",   64'(bus32.len_err),    64'(0));
      chk_eq("rst16_len_rdy", 64'(bus16.len_rdy),    64'(1));

      // Basic 8-word frame.
      push32(32'h10, 8);
      send_len32(5'd8);
      wait_beats(8, "basic");
      expect_frame("basic", 32'h10, 8, 0);
      chk_eq("basic_consec", 64'((q_cyc.size() >= 8) ? (q_cyc[7] - q_cyc[0]) : 999), 64'(7));
      repeat (5) tick();
      chk_eq("basic_no_extra", 64'(q_beat.size()), 64'(8));
      chk_eq("basic_idle_val", 64'(bus32.frame_val), 64'(0));

      // Lengths queued ahead of their data.
      q_beat.delete(); q_cyc.delete();
      send_len32(5'd3);
      send_len32(5'd1);
      send_len32(5'd4);
      repeat (4) tick();
      chk_eq("queued_nodata_val", 64'(bus32.frame_val), 64'(0));
      for (int i = 0; i < 8; i++) begin
         if (i < 3) chk_eq($sformatf("early_val%0d", i), 64'(bus32.frame_val), 64'(0));
         bus32.alu_ready = 1'b1;
         bus32.alu_data  = 32'h20 + 32'(i);
         tick();
      end
      bus32.alu_ready = 1'b0;
      wait_beats(8, "queued");
      expect_frame("q3", 32'h20, 3, 0);
      expect_frame("q1", 32'h23, 1, 3);
      expect_frame("q4", 32'h24, 4, 4);

      // Output backpressure during a 5-word frame.
      q_beat.delete(); q_cyc.delete();
      push32(32'h30, 5);
      send_len32(5'd5);
      k = 0;
      while (!bus32.frame_val && k < 50) begin
         tick();
         k++;
      end
      chk_eq("bp_first_val", 64'(bus32.frame_val), 64'(1));
      k = 0;
      while (q_beat.size() < 5 && k < 100) begin
         bus32.frame_rdy = pat[k % 4];
         tick();
         k++;
      end
      bus32.frame_rdy = 1'b1;
      repeat (5) tick();
      chk_eq("bp_beats", 64'(q_beat.size()), 64'(5));
      expect_frame("bp", 32'h30, 5, 0);

      // Fill to full, push+pop at full, then an overflowing push.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         if (i >= 28) chk_eq($sformatf("bp_at%0d", i), 64'(bus32.frame_bp), 64'(i >= 30));
         bus32.alu_ready = 1'b1;
         bus32.alu_data  = 32'h100 + 32'(i);
         tick();
      end
      bus32.alu_ready = 1'b0;
      send_len32(5'd1);
      tick();
      bus32.alu_ready = 1'b1;
      bus32.alu_data  = 32'h120;
      tick();
      bus32.alu_ready = 1'b0;
      chk_eq("full_pushpop_ovf", 64'(bus32.ovf_err), 64'(0));
      bus32.alu_ready = 1'b1;
      bus32.alu_data  = 32'h1FF;
      tick();
      bus32.alu_ready = 1'b0;
      chk_eq("ovf_set", 64'(bus32.ovf_err), 64'(1));
      repeat (5) tick();
      chk_eq("ovf_sticky", 64'(bus32.ovf_err), 64'(1));
      chk_eq("full_bp", 64'(bus32.frame_bp), 64'(1));
      send_len32(5'd31);
      send_len32(5'd1);
      wait_beats(33, "drain");
      expect_frame("full1", 32'h100, 1, 0);
      expect_frame("drain31", 32'h101, 31, 1);
      expect_frame("drain_last", 32'h120, 1, 32);
      repeat (4) tick();
      chk_eq("drained_bp", 64'(bus32.frame_bp), 64'(0));
      do_reset();
      chk_eq("ovf_cleared", 64'(bus32.ovf_err), 64'(0));

      // Zero and oversize lengths on the DEPTH=16 instance.
      lerr = 0;
      vals = 0;
      for (int i = 0; i < 12; i++) begin
         bus16.len_val = (i < 2);
         bus16.len_in  = (i == 0) ? 5'd0 : 5'd31;
         tick();
         lerr += int'(bus16.len_err);
         vals += int'(bus16.frame_val);
      end
      bus16.len_val = 1'b0;
      chk_eq("len_err_pulses", 64'(lerr), 64'(1));
      chk_eq("bad_len_no_frame", 64'(vals), 64'(0));
      for (int i = 0; i < 2; i++) begin
         bus16.alu_ready = 1'b1;
         bus16.alu_data  = 32'h40 + 32'(i);
         tick();
      end
      bus16.alu_ready = 1'b0;
      bus16.len_val = 1'b1;
      bus16.len_in  = 5'd2;
      tick();
      bus16.len_val = 1'b0;
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus16.frame_val) begin
            if (nb < 4) b16[nb] = {bus16.frame_sof, bus16.frame_eof, bus16.frame_data};
            nb++;
         end
         tick();
      end
      chk_eq("d16_beats", 64'(nb), 64'(2));
      chk_eq("d16_b0", 64'(b16[0]), 64'({1'b1, 1'b0, 32'h40}));
      chk_eq("d16_b1", 64'(b16[1]), 64'({1'b0, 1'b1, 32'h41}));

      // Reset on the third beat of a 6-word frame.
      q_beat.delete(); q_cyc.delete();
      push32(32'h50, 6);
      send_len32(5'd6);
      k = 0;
      while (!(bus32.frame_val && bus32.frame_data == 32'h52) && k < 50) begin
         tick();
         k++;
      end
      chk_eq("rstmid_third", 64'(bus32.frame_data), 64'(32'h52));
      rst_n = 1'b0;
      #1;
      chk_eq("rstmid_val",     64'(bus32.frame_val),  64'(0));
      chk_eq("rstmid_len_rdy", 64'(bus32.len_rdy),    64'(1));
      chk_eq("rstmid_sof",     64'(bus32.frame_sof),  64'(0));
      chk_eq("rstmid_data",    64'(bus32.frame_data), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      q_beat.delete(); q_cyc.delete();
      send_len32(5'd2);
      repeat (8) tick();
      chk_eq("pend_val", 64'(bus32.frame_val), 64'(0));
      chk_eq("pend_beats", 64'(q_beat.size()), 64'(0));
      push32(32'h60, 2);
      wait_beats(2, "post_rst");
      expect_frame("post_rst", 32'h60, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_pframer.md
# alu_pframer

Parametrised ALU result framer. It buffers ALU result words in a data FIFO and queues frame-length requests. For each request it emits one frame of exactly L words, marked with start/end-of-frame, on a valid/ready output port. It sits between the ALU output stage and the packet egress logic. Unlike the fixed 32-bit/32-deep framer, it accepts several outstanding length requests, honours downstream backpressure, and reports overflow and illegal lengths.

## Interface
- DATA_W, 32, ALU word width
- DEPTH, 32, data FIFO depth; power of 2, >= 4
- LEN_W, 5, frame length field width; 2^LEN_W-1 may exceed DEPTH
- LQ_DEPTH, 4, length queue depth; power of 2, >= 2
- BP_MARGIN, 3, frame_bp asserts when occupancy >= DEPTH-BP_MARGIN
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- len_in  in  LEN_W  requested frame length in words
- len_val  in  1  len_in valid
- len_rdy  out  1  length queue not full; a request is accepted on len_val && len_rdy
- alu_data  in  DATA_W  ALU result word
- alu_ready  in  1  write strobe for alu_data; no ready return
- frame_bp  out  1  backpressure to ALU
- frame_val  out  1  frame_data valid
- frame_rdy  in  1  downstream accepts the beat
- frame_data  out  DATA_W  frame word
- frame_sof  out  1  first beat of frame, qualified by frame_val
- frame_eof  out  1  last beat of frame, qualified by frame_val
- ovf_err  out  1  sticky; a write was dropped because the FIFO was full
- len_err  out  1  one-cycle pulse; an accepted length > DEPTH was discarded

## Operation
- Data FIFO occupancy counter is $clog2(DEPTH)+1 bits wide, so it never wraps.
- Push: alu_ready, unless the FIFO is full with no pop in the same cycle. In that case the word is dropped and ovf_err sets. A push and a pop while full are both legal.
- Length queue holds up to LQ_DEPTH requests. len_rdy = !lq_full.
- Lengths are classified when popped:
  - L == 0: discarded silently.
  - L > DEPTH: discarded, len_err pulses.
- FSM states: IDLE, PENDING, FRAMING.
  - IDLE: if the length queue is non-empty, pop it and load remaining = L. Go to FRAMING if occupancy >= L, else to PENDING. A discarded length stays in IDLE.
  - PENDING: go to FRAMING when occupancy >= remaining.
  - FRAMING: each pop moves one word into the output register and decrements remaining. After the last pop, go to IDLE. A whole frame is resident before FRAMING starts, so the output never underflows mid-frame.
- Output register:
  - Loads when empty or when the current beat is accepted (frame_val && frame_rdy).
  - frame_data, frame_sof and frame_eof hold stable while frame_val && !frame_rdy.
  - Frames are back-to-back: the next frame's sof beat may directly follow the previous eof beat.
- L == 1: a single beat with both frame_sof and frame_eof high.

## Timing
- Reset values: len_rdy=1, frame_bp=0, frame_val=0, frame_sof=0, frame_eof=0, frame_data=0, ovf_err=0, len_err=0, state IDLE, all pointers and counters 0.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). FIFO contents and pending requests are lost.
- alu_ready in cycle t: occupancy updates at t+1. frame_bp reflects the new occupancy at t+2 (registered).
- len_val && len_rdy in cycle t: the queue entry is visible at t+1. IDLE pops it and the FSM leaves IDLE at t+2.
- Entry to FRAMING at cycle f: first frame_val at f+1.
- With frame_rdy held high, one beat per cycle. An L-word frame occupies L consecutive cycles.
- len_err pulses the cycle after the illegal length is popped.

## Structure
- Package alu_framer_pkg:
  - FSM state enum (IDLE/PENDING/FRAMING)
  - default parameter constants
  - occupancy-width function
- Sub-module alu_sync_fifo (WIDTH, DEPTH parameters), instantiated twice:
  - data FIFO
  - length queue (WIDTH = LEN_W)
- Ports: push, pop, data, full, empty, count.

## Test plan
- Basic frame: DATA_W=32, DEPTH=32. Push 8 words 0x10..0x17, then len 8 → 8 beats of 0x10..0x17; sof on 0x10, eof on 0x17; state returns to IDLE.
- Queued lengths with no data: lengths 3, 1, 4 accepted, then 8 words pushed → three frames of 3, 1 and 4 beats in order. The 1-beat frame has sof=eof=1. frame_val is never high before all words of a frame are resident.
- Output backpressure: frame_rdy toggled 1,0,0,1 during a 5-word frame → data, sof and eof stable while stalled. Exactly 5 beats accepted with no loss or duplication.
- Full and overflow: push 32 words with no length pending → frame_bp high once occupancy >= 29. The 33rd push is dropped and ovf_err=1 until reset. A simultaneous push and pop at full sets no error.
- Illegal and zero lengths: len 0, then len 31 with DEPTH=16 → no frame for either. len_err pulses once (for the 31). A subsequent len 2 frames normally.
- Reset mid-frame: rst_n low on the 3rd beat of a 6-word frame → frame_val=0 and len_rdy=1 immediately. After reset, a new len 2 waits in PENDING until 2 fresh words are pushed.
